vt_sensor_spi_master: RTL

//  Host-side SPI initiator for the digital VT sensor's 64-bit SPI responder; drives SPI_CLK/SPI_CS/SPI_MOSI, captures SPI_MISO.
//  One full-duplex 64-bit frame per start request: i_txdata is the sensor config word (RO select [5:0], mux select [8:6]).
//  o_rxdata returns the sensor result word (ripple count [15:0], TDC thermometer [63:16]).

---
 rtl/vt_sensor_spi_master.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/vt_sensor_spi_master.sv
// Host-side SPI mode-0 initiator for the VT sensor's 64-bit responder.
// One full-duplex MSB-first frame per accepted start; MISO passes through a synchroniser.
module vt_sensor_spi_master #(
  parameter int FRAME_BITS  = 64,
  parameter int CLK_DIV     = 4,
  parameter int CS_SETUP    = 2,
  parameter int CS_HOLD     = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RSTHIGH,
  input  logic                  i_start,
  input  logic [FRAME_BITS-1:0] i_txdata,
  output logic                  o_busy,
  output logic [FRAME_BITS-1:0] o_rxdata,
  output logic                  o_rxdv,
  output logic                  SPI_CLK,
  output logic                  SPI_CS,
  output logic                  SPI_MOSI,
  input  logic                  SPI_MISO
);

  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [7:0]    DIV_LAST   = 8'(CLK_DIV - 1);
  localparam logic [7:0]    SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0]    HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              phase_q, phase_d;
  logic [BW-1:0]           bitcnt_q, bitcnt_d;
  logic [FRAME_BITS-1:0]   tx_q, tx_d;
  logic [FRAME_BITS-1:0]   rx_q, rx_d;
  logic [FRAME_BITS-1:0]   rxdata_q, rxdata_d;
  logic [SYNC_STAGES-1:0]  sync_q, sync_d;
  logic                    sclk_q, sclk_d;
  logic                    cs_q, cs_d;
  logic                    mosi_q, mosi_d;
  logic                    busy_q, busy_d;
  logic                    rxdv_q, rxdv_d;
  logic                    miso_sync;
  logic                    phase_done;

  // MISO synchroniser shift; its last stage is the only value the FSM samples
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], SPI_MISO};
    miso_sync = sync_q[SYNC_STAGES-1];
  end

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    bitcnt_d   = bitcnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rxdata_d   = rxdata_q;
    sclk_d     = sclk_q;
    cs_d       = cs_q;
    mosi_d     = mosi_q;
    rxdv_d     = 1'b0;
    phase_done = (phase_q == 8'd0);

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          // tx_q holds the bits still to send, left-aligned after the MSB
          tx_d     = {i_txdata[FRAME_BITS-2:0], 1'b0};
          mosi_d   = i_txdata[FRAME_BITS-1];
          bitcnt_d = '0;
          cs_d     = 1'b0;
          sclk_d   = 1'b0;
          phase_d  = SETUP_LAST;
          state_d  = ST_SETUP;
        end else begin
          cs_d   = 1'b1;
          sclk_d = 1'b0;
          mosi_d = 1'b0;
        end
      end

      ST_SETUP: begin
        if (phase_done) begin
          sclk_d  = 1'b1;
          phase_d = DIV_LAST;
          state_d = ST_HIGH;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end

      ST_HIGH: begin
        if (phase_done) begin
          rx_d   = {rx_q[FRAME_BITS-2:0], miso_sync};
          sclk_d = 1'b0;
          if (bitcnt_q == BIT_LAST) begin
            phase_d = HOLD_LAST;
            state_d = ST_HOLD;
          end else begin
            mosi_d   = tx_q[FRAME_BITS-1];
            tx_d     = {tx_q[FRAME_BITS-2:0], 1'b0};
            bitcnt_d = bitcnt_q + BW'(1);
            phase_d  = DIV_LAST;
            state_d  = ST_LOW;
          end
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end

      ST_LOW: begin
        if (phase_done) begin
          sclk_d  = 1'b1;
          phase_d = DIV_LAST;
          state_d = ST_HIGH;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end

      ST_HOLD: begin
        if (phase_done) begin
          cs_d     = 1'b1;
          mosi_d   = 1'b0;
          rxdata_d = rx_q;
          rxdv_d   = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          phase_d = phase_q - 8'd1;
        end
      end

      default: begin
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RSTHIGH) begin
      state_q  <= ST_IDLE;
      phase_q  <= 8'd0;
      bitcnt_q <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      rxdata_q <= '0;
      sync_q   <= '0;
      sclk_q   <= 1'b0;
      cs_q     <= 1'b1;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      rxdv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      bitcnt_q <= bitcnt_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      rxdata_q <= rxdata_d;
      sync_q   <= sync_d;
      sclk_q   <= sclk_d;
      cs_q     <= cs_d;
      mosi_q   <= mosi_d;
      busy_q   <= busy_d;
      rxdv_q   <= rxdv_d;
    end
  end

  assign o_busy   = busy_q;
  assign o_rxdata = rxdata_q;
  assign o_rxdv   = rxdv_q;
  assign SPI_CLK  = sclk_q;
  assign SPI_CS   = cs_q;
  assign SPI_MOSI = mosi_q;

endmodule
